muldiv_result_hold: RTL and testbench

MULDIV_RESULT_HOLD -- requirements
Module: muldiv_result_hold

---
 rtl/muldiv_result_hold_pkg.sv | 25 ++
 rtl/muldiv_result_hold_chan.sv | 40 ++++
 rtl/muldiv_result_hold.sv | 132 +++++++++++++
 tb/tb_muldiv_result_hold.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_result_hold_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_result_hold_pkg
//   Shared definitions for the mul/div result-hold logic.
//   - md_state_e : FSM encoding (IDLE=0, BUSY=1, HOLD=2)
//   - SEL_HELD / SEL_UNIT : per-channel result source select values
//   - sat_inc32 : saturating 32-bit increment used by the HOLD statistic
// ---------------------------------------------------------------------------
package muldiv_result_hold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } md_state_e;

    localparam logic SEL_HELD = 1'b0;
    localparam logic SEL_UNIT = 1'b1;

    localparam int HOLD_CNT_W = 32;

    function automatic logic [HOLD_CNT_W-1:0] sat_inc32(input logic [HOLD_CNT_W-1:0] v);
        return (v == {HOLD_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/muldiv_result_hold_chan.sv
// ---------------------------------------------------------------------------
// muldiv_hold_chan
//   One result channel: a held copy of the mul/div result plus the output
//   mux choosing between the live unit value and the held copy.
//   State updates on the falling edge of clk_i.
//
//   Ports
//     clk_i      in   clock (falling-edge state update)
//     reset_i    in   synchronous active-high reset, clears the held copy
//     capture_i  in   load live_i into the held copy on this edge
//     live_i     in   live unit result for this channel
//     sel_i      in   SEL_UNIT = pass live_i, SEL_HELD = pass held copy
//     result_o   out  selected value (combinational)
// ---------------------------------------------------------------------------
module muldiv_hold_chan
    import muldiv_result_hold_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] live_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] held_q;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            held_q <= '0;
        end else if (capture_i) begin
            held_q <= live_i;
        end
    end

    assign result_o = (sel_i == SEL_UNIT) ? live_i : held_q;

endmodule

// File: rtl/muldiv_result_hold.sv
// ---------------------------------------------------------------------------
// muldiv_result_hold
//   Keeps the mul/div result stable while the pipeline is stalled by
//   something other than the mul/div unit itself. While the unit computes
//   (ex_stall_i) the FSM sits in BUSY; if the unit finishes while fetch or
//   memory is still stalled, the selected channels are captured and the
//   FSM parks in HOLD, disabling the unit and serving the held copies.
//   All state updates on the falling edge of clk_i.
//
//   Optional feature: define MULDIV_HOLD_STAT_EN to build a saturating
//   counter of cycles spent in HOLD on hold_cycles_o; otherwise that
//   output is constant 0 and no counter exists.
//
//   Ports
//     clk_i          in   clock (falling-edge state update)
//     reset_i        in   synchronous active-high reset
//     if_stall_i     in   fetch-stage stall
//     ex_stall_i     in   execute-stage stall (mul/div computing)
//     mem_stall_i    in   memory-stage stall
//     flush_i        in   pipeline flush, abandons any held result
//     cap_mask_i     in   [NUM_CH] per-channel capture enable
//     md_result_i    in   [NUM_CH*WIDTH] live unit results, ch k at k*WIDTH
//     md_en_o        out  mul/div unit enable (0 only in HOLD)
//     result_sel_o   out  [NUM_CH] 1 = live, 0 = held
//     result_o       out  [NUM_CH*WIDTH] per-channel muxed result
//     hold_o         out  high while in HOLD
//     hold_cycles_o  out  [32] HOLD cycle count (0 without the feature)
//     dbg_state_o    out  current FSM state, for observation
//
//   Handshake: there is no valid/ready pair; the block is a level-driven
//   follower of the stall signals and its outputs are valid every cycle.
// ---------------------------------------------------------------------------
module muldiv_result_hold
    import muldiv_result_hold_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    if_stall_i,
    input  logic                    ex_stall_i,
    input  logic                    mem_stall_i,
    input  logic                    flush_i,
    input  logic [NUM_CH-1:0]       cap_mask_i,
    input  logic [NUM_CH*WIDTH-1:0] md_result_i,
    output logic                    md_en_o,
    output logic [NUM_CH-1:0]       result_sel_o,
    output logic [NUM_CH*WIDTH-1:0] result_o,
    output logic                    hold_o,
    output logic [31:0]             hold_cycles_o,
    output md_state_e               dbg_state_o
);

    md_state_e         state_q;
    logic [NUM_CH-1:0] mask_q;
    logic              non_stall;
    logic              other_stall;
    logic              capture;

    assign non_stall   = ~(if_stall_i | ex_stall_i | mem_stall_i);
    // Unit finished but a neighbouring stage is still stalled.
    assign other_stall = ~ex_stall_i & (if_stall_i | mem_stall_i);
    // Flush and reset both suppress the capture on the edge they act.
    assign capture     = ~reset_i & ~flush_i & (state_q == BUSY) & other_stall;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_stall_i) state_q <= BUSY;
                end
                BUSY: begin
                    if (non_stall) begin
                        state_q <= IDLE;
                    end else if (other_stall) begin
                        state_q <= HOLD;
                        mask_q  <= cap_mask_i;
                    end
                end
                HOLD: begin
                    if (non_stall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode from registered state only.
    assign md_en_o     = (state_q != HOLD);
    assign hold_o      = (state_q == HOLD);
    assign dbg_state_o = state_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        // Outside HOLD every channel is live; in HOLD only captured ones
        // switch to their held copy.
        assign result_sel_o[k] = (hold_o && mask_q[k]) ? SEL_HELD : SEL_UNIT;

        muldiv_hold_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .capture_i(capture & cap_mask_i[k]),
            .live_i   (md_result_i[k*WIDTH +: WIDTH]),
            .sel_i    (result_sel_o[k]),
            .result_o (result_o[k*WIDTH +: WIDTH])
        );
    end

`ifdef MULDIV_HOLD_STAT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt_q;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            hold_cnt_q <= '0;
        end else if (state_q == HOLD) begin
            hold_cnt_q <= sat_inc32(hold_cnt_q);
        end
    end

    assign hold_cycles_o = hold_cnt_q;
`else
    assign hold_cycles_o = '0;
`endif

endmodule

// File: tb/tb_muldiv_result_hold.sv
// ---------------------------------------------------------------------------
// tb_muldiv_result_hold
//   Driver pushes the expected outputs of each cycle into exp_q; a monitor
//   pops and compares one entry per cycle. The reference model follows the
//   written transition rules with plain variables.
// ---------------------------------------------------------------------------
module tb_muldiv_result_hold;
    import muldiv_result_hold_pkg::*;

    localparam int W  = 32;
    localparam int NC = 2;
    // {state[2], md_en, sel[2], hold, cnt[32], result[64]}
    localparam int EW = 2 + 1 + NC + 1 + 32 + NC*W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i = 1'b1;
    logic              if_stall_i = 1'b0, ex_stall_i = 1'b0, mem_stall_i = 1'b0;
    logic              flush_i = 1'b0;
    logic [NC-1:0]     cap_mask_i = '0;
    logic [NC*W-1:0]   md_result_i = '0;
    logic              md_en_o;
    logic [NC-1:0]     result_sel_o;
    logic [NC*W-1:0]   result_o;
    logic              hold_o;
    logic [31:0]       hold_cycles_o;
    md_state_e         dbg_state_o;

    muldiv_result_hold #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .if_stall_i   (if_stall_i),
        .ex_stall_i   (ex_stall_i),
        .mem_stall_i  (mem_stall_i),
        .flush_i      (flush_i),
        .cap_mask_i   (cap_mask_i),
        .md_result_i  (md_result_i),
        .md_en_o      (md_en_o),
        .result_sel_o (result_sel_o),
        .result_o     (result_o),
        .hold_o       (hold_o),
        .hold_cycles_o(hold_cycles_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 busy (unit computing), 2 holding a captured result
    int           m_mode = 0;
    logic [W-1:0] m_held[NC];
    logic [NC-1:0] m_mask = '0;
    longint       m_cnt = 0;
`ifdef MULDIV_HOLD_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    task automatic model_edge_and_push();
        logic [EW-1:0]   e;
        logic [NC-1:0]   sel;
        logic [NC*W-1:0] res;
        bit any_stall;
        bit other;
        any_stall = if_stall_i || ex_stall_i || mem_stall_i;
        other     = !ex_stall_i && (if_stall_i || mem_stall_i);
        if (reset_i) begin
            m_mode = 0; m_mask = '0; m_cnt = 0;
            for (int k = 0; k < NC; k++) m_held[k] = '0;
        end else begin
            if (m_mode == 2 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush_i) m_mode = 0;
            else if (m_mode == 0) m_mode = ex_stall_i ? 1 : 0;
            else if (m_mode == 1) begin
                if (!any_stall) m_mode = 0;
                else if (other) begin
                    m_mode = 2;
                    m_mask = cap_mask_i;
                    for (int k = 0; k < NC; k++)
                        if (cap_mask_i[k]) m_held[k] = md_result_i[k*W +: W];
                end
            end else if (!any_stall) m_mode = 0;
        end
        for (int k = 0; k < NC; k++) begin
            sel[k] = !(m_mode == 2 && m_mask[k]);
            res[k*W +: W] = sel[k] ? md_result_i[k*W +: W] : m_held[k];
        end
        e = {2'(m_mode), (m_mode != 2), sel, (m_mode == 2),
             (STAT ? 32'(m_cnt) : 32'd0), res};
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit ifs, input bit exs, input bit mems,
                        input bit fl, input logic [NC-1:0] mask, input logic [NC*W-1:0] res);
        @(posedge clk);
        #2;
        reset_i = rst; if_stall_i = ifs; ex_stall_i = exs; mem_stall_i = mems;
        flush_i = fl; cap_mask_i = mask; md_result_i = res;
        model_edge_and_push();
    endtask

    function automatic logic [NC*W-1:0] rnd_res();
        return {$urandom(), $urandom()};
    endfunction

    // Busy for 3 cycles, then a memory stall of `n` cycles, then release.
    task automatic hold_seq(input logic [NC-1:0] mask, input int n);
        repeat (3) step(0, 0, 1, 0, 0, mask, rnd_res());
        step(0, 0, 0, 1, 0, mask, {32'hDEAD_BEEF, 32'h1234_5678});
        repeat (n - 1) step(0, 0, 0, 1, 0, mask, rnd_res());
        step(0, 0, 0, 0, 0, mask, rnd_res());
        step(0, 0, 0, 0, 0, mask, rnd_res());
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",       64'(dbg_state_o),   64'(e[EW-1 -: 2]));
                chk("md_en",       64'(md_en_o),       64'(e[EW-3]));
                chk("result_sel",  64'(result_sel_o),  64'(e[EW-4 -: NC]));
                chk("hold",        64'(hold_o),        64'(e[32+NC*W]));
                chk("hold_cycles", 64'(hold_cycles_o), 64'(e[NC*W +: 32]));
                chk("result_lo",   64'(result_o[0 +: W]), 64'(e[0 +: W]));
                chk("result_hi",   64'(result_o[W +: W]), 64'(e[W +: W]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < NC; k++) m_held[k] = '0;

        // reset then quiet idle cycles
        repeat (2) step(1, 0, 0, 0, 0, 2'b00, rnd_res());
        repeat (5) step(0, 0, 0, 0, 0, 2'b00, rnd_res());

        // full capture, then LO-only capture
        hold_seq(2'b11, 4);
        hold_seq(2'b01, 4);

        // release straight from busy: no capture
        step(1, 0, 0, 0, 0, 2'b11, rnd_res());
        repeat (3) step(0, 0, 1, 0, 0, 2'b11, rnd_res());
        step(0, 0, 0, 0, 0, 2'b11, rnd_res());
        step(0, 0, 0, 0, 0, 2'b11, rnd_res());

        // flush while holding
        repeat (2) step(0, 0, 1, 0, 0, 2'b11, rnd_res());
        step(0, 1, 0, 0, 0, 2'b11, rnd_res());
        step(0, 1, 0, 0, 0, 2'b11, rnd_res());
        step(0, 1, 0, 0, 1, 2'b11, rnd_res());
        step(0, 1, 0, 0, 0, 2'b11, rnd_res());

        // reset while busy
        repeat (2) step(0, 0, 1, 0, 0, 2'b11, rnd_res());
        step(1, 0, 1, 0, 0, 2'b11, rnd_res());
        step(0, 1, 0, 0, 0, 2'b11, rnd_res());

`ifdef MULDIV_HOLD_STAT_EN
        // saturation: preload the counter near its top
        @(posedge clk);
        #2;
        reset_i = 0; if_stall_i = 0; ex_stall_i = 0; mem_stall_i = 0; flush_i = 0;
        force dut.hold_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hold_cnt_q;
        m_cnt = 64'hFFFF_FFFE;
        model_edge_and_push();
        step(0, 0, 1, 0, 0, 2'b11, rnd_res());
        repeat (4) step(0, 0, 0, 1, 0, 2'b11, rnd_res());
        step(0, 0, 0, 0, 0, 2'b11, rnd_res());
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 60) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 30) == 0,
                 NC'($urandom_range(0, 3)),
                 rnd_res());
        end

        // let the monitor drain the last entry
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
